// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2-read/1-write integer register file with a per-register
// busy scoreboard. Decode reads operands and hazard status combinationally,
// issue marks a destination pending, writeback commits data and clears pending.
// No valid/ready handshakes: every input is sampled unconditionally at posedge.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              flush,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int NREGS = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic wr_legal;
  logic set_legal;
  logic clr_eff;
  logic cnt_inc;
  logic cnt_dec;

  // Qualify writeback/issue: reg 0 is not writable and never tracked when hardwired.
  // A clear that hits the register being issued this cycle loses to the new producer.
  always_comb begin
    wr_legal  = we && !((ZERO_REG != 0) && (wa == '0));
    set_legal = issue_en && !flush && !((ZERO_REG != 0) && (issue_rd == '0));
    clr_eff   = we && !(set_legal && (issue_rd == wa));
    cnt_inc   = set_legal && !busy_q[issue_rd];
    cnt_dec   = clr_eff && busy_q[wa];
  end

  // Next scoreboard state and incremental pending count (tracks popcount of busy).
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      if (clr_eff)   busy_d[wa]       = 1'b0;
      if (set_legal) busy_d[issue_rd] = 1'b1;
      cnt_d = cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    end
  end

  // Scoreboard and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Register array: cleared on reset, one write per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_legal) begin
      regs_q[wa] <= wd;
    end
  end

  // Read port 1: hardwired zero beats bypass, bypass beats stored value.
  always_comb begin
    rd1 = regs_q[ra1];
    if ((BYPASS != 0) && wr_legal && (wa == ra1)) rd1 = wd;
    if ((ZERO_REG != 0) && (ra1 == '0))           rd1 = '0;
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rd2 = regs_q[ra2];
    if ((BYPASS != 0) && wr_legal && (wa == ra2)) rd2 = wd;
    if ((ZERO_REG != 0) && (ra2 == '0))           rd2 = '0;
  end

  // Hazard status: a same-cycle writeback to the read register is forwarded, so not busy.
  always_comb begin
    busy1 = busy_q[ra1];
    busy2 = busy_q[ra2];
    if ((BYPASS != 0) && we && (wa == ra1)) busy1 = 1'b0;
    if ((BYPASS != 0) && we && (wa == ra2)) busy2 = 1'b0;
  end

  assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed scenarios plus randomized issue/writeback/flush
// traffic against an array-based reference model of the register file.
module tb_regfile_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] ra1, ra2, wa, issue_rd;
  logic [DW-1:0] rd1, rd2, wd;
  logic          busy1, busy2, we, issue_en, flush;
  logic [AW:0]   pending_cnt;

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2),
    .we(we), .wa(wa), .wd(wd),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush),
    .pending_cnt(pending_cnt)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural view: plain array of values and a set of pending registers.
  bit [DW-1:0] m_regs [32];
  bit [31:0]   m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
      m_busy <= '0;
    end else begin
      if (we && wa != 0) m_regs[wa] <= wd;
      if (flush) m_busy <= '0;
      else begin
        // Issue is applied after writeback so a new producer keeps the register pending.
        if (we) m_busy[wa] <= 1'b0;
        if (issue_en && issue_rd != 0) m_busy[issue_rd] <= 1'b1;
      end
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra);
    if (ra == 0) return '0;
    if (we && wa == ra) return wd;
    return m_regs[ra];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] ra);
    if (we && wa == ra) return 1'b0;
    return m_busy[ra];
  endfunction

  // Compare process: every cycle, mid-period, all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_q.push_back(exp_rd(ra1));
      exp_q.push_back(exp_rd(ra2));
      check("rd1", rd1, exp_q.pop_front());
      check("rd2", rd2, exp_q.pop_front());
      check("busy1", {31'd0, busy1}, {31'd0, exp_busy(ra1)});
      check("busy2", {31'd0, busy2}, {31'd0, exp_busy(ra2)});
      check("pending_cnt", {26'd0, pending_cnt}, $countones(m_busy));
      check("cnt_le_max", {31'd0, (pending_cnt <= 6'd31)}, 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; issue_en = 0; flush = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    ra1 = 0; ra2 = 0; wa = 0; wd = 0; issue_rd = 0;
    idle();
    #1 rst_n = 1'b0;
    #2;
    check("reset_rd1", rd1, 32'd0);
    check("reset_busy1", {31'd0, busy1}, 32'd0);
    check("reset_cnt", {26'd0, pending_cnt}, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // 1: write x5, read next cycle
    cyc(); we = 1; wa = 5; wd = 32'hDEADBEEF; ra1 = 1;
    cyc(); idle(); ra1 = 5;
    #1;
    check("t1_rd1", rd1, 32'hDEADBEEF);
    check("t1_busy1", {31'd0, busy1}, 32'd0);

    // 2: reg 0 ignores write and issue
    cyc(); we = 1; wa = 0; wd = 32'h1234; issue_en = 1; issue_rd = 0; ra1 = 0;
    #1;
    check("t2_rd1_same", rd1, 32'd0);
    cyc(); idle();
    #1;
    check("t2_rd1", rd1, 32'd0);
    check("t2_busy1", {31'd0, busy1}, 32'd0);
    check("t2_cnt", {26'd0, pending_cnt}, 32'd0);

    // 3: same-cycle bypass
    cyc(); we = 1; wa = 7; wd = 32'hA5A5A5A5; ra2 = 7;
    #1;
    check("t3_bypass", rd2, 32'hA5A5A5A5);
    cyc(); idle();
    #1;
    check("t3_stored", rd2, 32'hA5A5A5A5);

    // 4: issue x3, x4; clear x3; set+clear x4 same cycle
    cyc(); issue_en = 1; issue_rd = 3;
    cyc(); issue_rd = 4;
    cyc(); idle(); ra1 = 3; ra2 = 4;
    #1;
    check("t4_busy_x3", {31'd0, busy1}, 32'd1);
    check("t4_busy_x4", {31'd0, busy2}, 32'd1);
    check("t4_cnt2", {26'd0, pending_cnt}, 32'd2);
    cyc(); we = 1; wa = 3; wd = 32'h33;
    #1;
    check("t4_busy_fwd", {31'd0, busy1}, 32'd0);
    cyc(); idle();
    #1;
    check("t4_x3_clear", {31'd0, busy1}, 32'd0);
    check("t4_cnt1", {26'd0, pending_cnt}, 32'd1);
    cyc(); issue_en = 1; issue_rd = 4; we = 1; wa = 4; wd = 32'h44;
    cyc(); idle();
    #1;
    check("t4_x4_stays", {31'd0, busy2}, 32'd1);
    check("t4_cnt_waw", {26'd0, pending_cnt}, 32'd1);
    check("t4_rd_x4", rd2, 32'h44);

    // 5: issue x1..x8, then flush with a competing issue of x9
    for (int i = 1; i <= 8; i++) begin
      cyc(); issue_en = 1; issue_rd = AW'(i);
    end
    cyc(); idle();
    #1;
    check("t5_cnt8", {26'd0, pending_cnt}, 32'd8);
    cyc(); flush = 1; issue_en = 1; issue_rd = 9;
    cyc(); idle(); ra1 = 9; ra2 = 1;
    #1;
    check("t5_x9_idle", {31'd0, busy1}, 32'd0);
    check("t5_x1_idle", {31'd0, busy2}, 32'd0);
    check("t5_cnt0", {26'd0, pending_cnt}, 32'd0);

    // 6: asynchronous reset between edges
    cyc(); issue_en = 1; issue_rd = 10;
    cyc(); idle(); ra1 = 5; ra2 = 10;
    #1;
    check("t6_pre_rd1", rd1, 32'hDEADBEEF);
    check("t6_pre_busy2", {31'd0, busy2}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rd1", rd1, 32'd0);
    check("t6_rd2", rd2, 32'd0);
    check("t6_busy2", {31'd0, busy2}, 32'd0);
    check("t6_cnt", {26'd0, pending_cnt}, 32'd0);
    cyc(); rst_n = 1'b1;

    // Randomized traffic; narrow address pool half the time to force collisions.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      we       = ($urandom_range(0, 1) == 1);
      wa       = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
      wd       = $urandom;
      issue_en = ($urandom_range(0, 9) < 6);
      issue_rd = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
      flush    = ($urandom_range(0, 49) == 0);
      ra1      = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
      ra2      = ($urandom_range(0, 3) == 0) ? issue_rd : AW'($urandom_range(0, 7));
    end
    cyc(); idle();
    cyc();
    #6;
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
